// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads inst_memory combinationally and
// buffers {pc, word} in a small FIFO toward decode, with redirect and halt.
module fetch_unit #(
  parameter int INST_WIDTH             = 32,
  parameter int INST_MEM_ADD_BIT_WIDTH = 16,
  parameter int RESET_PC               = 0,
  parameter int FIFO_DEPTH             = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INST_MEM_ADD_BIT_WIDTH-1:0] inst_add,
  input  logic [INST_WIDTH-1:0]             inst_data,
  input  logic                              redirect_valid,
  input  logic [INST_MEM_ADD_BIT_WIDTH-1:0] redirect_pc,
  input  logic                              halt_req,
  output logic                              fetch_valid,
  input  logic                              fetch_ready,
  output logic [INST_WIDTH-1:0]             fetch_inst,
  output logic [INST_MEM_ADD_BIT_WIDTH-1:0] fetch_pc,
  output logic                              addr_err,
  output logic                              halted
);
  localparam int AW = INST_MEM_ADD_BIT_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t          state, next_state;
  logic [AW-1:0]   pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [AW-1:0]   buf_pc   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] buf_inst [FIFO_DEPTH];
  logic            push, pop;

  assign fetch_valid = (count != '0);
  assign pop         = fetch_valid & fetch_ready;
  // A pop in the same edge frees the slot, so a full buffer still streams.
  assign push        = (state == FETCH) & ~redirect_valid &
                       ((count < CW'(FIFO_DEPTH)) | pop);
  assign inst_add    = pc;
  assign fetch_inst  = fetch_valid ? buf_inst[rd_ptr] : '0;
  assign fetch_pc    = fetch_valid ? buf_pc[rd_ptr]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH:   next_state = (halt_req && !redirect_valid) ? HALTED : FETCH;
      HALTED:  next_state = redirect_valid ? FETCH : HALTED;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    halted = (state == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= AW'(RESET_PC);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        // Flush wins over any same-cycle pop; target is forced word-aligned.
        pc     <= {redirect_pc[AW-1:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + AW'(4);
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= pc;
      buf_inst[wr_ptr] <= inst_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all compared
// against a queue-based model of the fetch stream.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst_add;
  logic [31:0] inst_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_inst;
  logic [15:0] fetch_pc;
  logic        addr_err;
  logic        halted;

  int n_asrt = 0;
  int n_fail = 0;

  // Model: 0 = waiting after reset, 1 = fetching, 2 = halted
  int          m_mode;
  logic [15:0] m_pc;
  logic        m_err;
  logic [15:0] q[$];

  fetch_unit #(.INST_WIDTH(32), .INST_MEM_ADD_BIT_WIDTH(16), .RESET_PC(0),
               .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inst_add(inst_add), .inst_data(inst_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .addr_err(addr_err),
    .halted(halted));

  always #5 clk = ~clk;

  // Memory word n at byte address 4n holds 0x1000_0000 + n.
  assign inst_data = 32'h1000_0000 + 32'(inst_add >> 2);

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return 32'h1000_0000 + 32'(a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 16'h0000;
    m_err  = 1'b0;
    q.delete();
  endtask

  // Check current outputs, advance the model by one edge, move to next negedge.
  task automatic tick();
    logic pop;
    chk("fetch_valid", 32'(fetch_valid), 32'(q.size() != 0));
    chk("inst_add", 32'(inst_add), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("addr_err", 32'(addr_err), 32'(m_err));
    if (q.size() != 0) begin
      chk("fetch_pc", 32'(fetch_pc), 32'(q[0]));
      chk("fetch_inst", fetch_inst, word_at(q[0]));
    end
    pop = (q.size() != 0) && fetch_ready;
    if (redirect_valid) begin
      q.delete();
      m_pc   = redirect_pc & 16'hFFFC;
      m_err  = (redirect_pc[1:0] != 2'b00);
      m_mode = 1;
    end else begin
      m_err = 1'b0;
      if (pop) void'(q.pop_front());
      if (m_mode == 1 && q.size() < DEPTH) begin
        q.push_back(m_pc);
        m_pc = m_pc + 16'd4;
      end
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && halt_req) m_mode = 2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Assert reset asynchronously and check outputs before any clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_inst_add", 32'(inst_add), 32'h0000);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'h0000);
    chk("rst_fetch_inst", fetch_inst, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    async_reset();

    // Streaming from reset, one per cycle
    fetch_ready = 1'b1;
    ticks(8);

    // Backpressure saturates the buffer, then drain in order
    async_reset();
    fetch_ready = 1'b1;
    ticks(3);
    fetch_ready = 1'b0;
    ticks(5);
    fetch_ready = 1'b1;
    ticks(5);

    // Redirect with a full buffer and a same-cycle pop
    fetch_ready = 1'b0;
    ticks(3);
    fetch_ready = 1'b1;
    redirect(16'h0100);
    ticks(4);

    // Misaligned target
    redirect(16'h0206);
    ticks(4);

    // Address wrap
    redirect(16'hFFFC);
    ticks(5);

    // Halt then resume via redirect
    redirect(16'h0020);
    halt_req = 1'b1;
    tick();
    ticks(4);
    halt_req = 1'b0;
    redirect(16'h0040);
    ticks(4);

    // Redirect in the same cycle as halt_req: redirect wins, halt next cycle
    halt_req = 1'b1;
    redirect(16'h0080);
    ticks(3);
    halt_req = 1'b0;
    redirect(16'h0000);
    ticks(2);

    // Reset mid-stream with a full buffer
    fetch_ready = 1'b0;
    ticks(4);
    async_reset();
    fetch_ready = 1'b1;
    ticks(5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 16'($urandom);
      halt_req       = ($urandom_range(0, 19) == 0);
      tick();
    end
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
